wb_port_arbiter: RTL and testbench

- Shares the single register-file write port (wea/w1/wdata) between two sources:
  - Source A: the in-order pipeline write-back. It has no backpressure and always has priority.
  - Source B: the multi-cycle unit (mul/div/load). It uses a valid/ready handshake and is buffered in a small FIFO.
- Keeps a 32-bit pending-write scoreboard so decode stalls on RAW/WAW hazards against outstanding B results.
- Sits between the WB stage, the multi-cycle unit and the 32x32 register file.

---
 rtl/wb_port_arbiter_if.sv | 41 ++++
 rtl/wb_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Bundle of signals around the register-file write-port arbiter: pipeline write-back (A),
// multi-cycle results (B), issue/decode lookups and the shared register-file write port.
interface wb_port_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          a_valid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;

    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;

    logic          iss_valid;
    logic [AW-1:0] iss_addr;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic          hazard;

    logic          wea;
    logic [AW-1:0] w1;
    logic [DW-1:0] wdata;
    logic [31:0]   pending;
    logic          err;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output iss_valid, iss_addr, rs_addr, rt_addr,
        input  b_ready, hazard, wea, w1, wdata, pending, err
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  iss_valid, iss_addr, rs_addr, rt_addr,
        output b_ready, hazard, wea, w1, wdata, pending, err
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: A (pipeline write-back) has priority, B (multi-cycle unit)
// is queued in a small FIFO and tracked by a pending-write scoreboard. Option macro: WB_BYPASS_EN.
module wb_port_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input logic clk,
    input logic rst,
    wb_port_arbiter_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ready_en;

    logic          wea_q;
    logic [AW-1:0] w1_q;
    logic [DW-1:0] wdata_q;
    logic          src_b;
    logic [31:0]   pending_q;
    logic          err_q;

    logic          wea_d;
    logic [AW-1:0] w1_d;
    logic [DW-1:0] wdata_d;
    logic          src_b_d;
    logic [31:0]   pending_d;
    logic          err_d;

    logic a_win;
    logic b_req;
    logic fifo_empty;
    logic push;
    logic pop;
    logic bypass;

    function automatic logic pend_bit(input logic [31:0] vec, input logic [AW-1:0] addr);
        return (addr != '0) && vec[addr];
    endfunction

    // ready_en keeps b_ready low through reset and for the first edge after release
    assign bus.b_ready = ready_en && (count != CW'(DEPTH));

    assign a_win      = bus.a_valid && (bus.a_addr != '0);
    assign b_req      = bus.b_valid && (bus.b_addr != '0);
    assign fifo_empty = (count == '0);

`ifdef WB_BYPASS_EN
    assign bypass = fifo_empty && !a_win && b_req && bus.b_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = b_req && bus.b_ready && !bypass;
    assign pop  = !a_win && !fifo_empty;

    // Write-port selection: A first, then FIFO head, then (optionally) a direct B result
    always_comb begin
        wea_d   = 1'b0;
        w1_d    = w1_q;
        wdata_d = wdata_q;
        src_b_d = 1'b0;
        if (a_win) begin
            wea_d   = 1'b1;
            w1_d    = bus.a_addr;
            wdata_d = bus.a_data;
        end else if (pop) begin
            wea_d   = 1'b1;
            w1_d    = mem_addr[rd_ptr];
            wdata_d = mem_data[rd_ptr];
            src_b_d = 1'b1;
        end else if (bypass) begin
            wea_d   = 1'b1;
            w1_d    = bus.b_addr;
            wdata_d = bus.b_data;
            src_b_d = 1'b1;
        end
    end

    // A set from a fresh issue overrides the clear from a commit to the same register
    always_comb begin
        pending_d = pending_q;
        if (wea_q && src_b) begin
            pending_d[w1_q] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_addr != '0)) begin
            pending_d[bus.iss_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        err_d = err_q;
        if (a_win && pend_bit(pending_q, bus.a_addr)) begin
            err_d = 1'b1;
        end
        if (b_req && !pend_bit(pending_q, bus.b_addr)) begin
            err_d = 1'b1;
        end
        if (bus.iss_valid && pend_bit(pending_q, bus.iss_addr)) begin
            err_d = 1'b1;
        end
    end

    assign bus.hazard = pend_bit(pending_q, bus.rs_addr)
                      | pend_bit(pending_q, bus.rt_addr)
                      | (bus.iss_valid && pend_bit(pending_q, bus.iss_addr));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read once count says they are valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= bus.b_addr;
            mem_data[wr_ptr] <= bus.b_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wea_q     <= 1'b0;
            w1_q      <= '0;
            wdata_q   <= '0;
            src_b     <= 1'b0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wea_q     <= wea_d;
            w1_q      <= w1_d;
            wdata_q   <= wdata_d;
            src_b     <= src_b_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign bus.wea     = wea_q;
    assign bus.w1      = w1_q;
    assign bus.wdata   = wdata_q;
    assign bus.pending = pending_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: priority, FIFO ordering, scoreboard, error and reset behaviour.
module tb_wb_port_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wb_port_arbiter_if #(.AW(5), .DW(32)) ifc ();

    wb_port_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.a_valid   = 1'b0;
        ifc.a_addr    = '0;
        ifc.a_data    = '0;
        ifc.b_valid   = 1'b0;
        ifc.b_addr    = '0;
        ifc.b_data    = '0;
        ifc.iss_valid = 1'b0;
        ifc.iss_addr  = '0;
        ifc.rs_addr   = '0;
        ifc.rt_addr   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #1;
        checks++;
        if (ifc.wea !== 1'b0 || ifc.w1 !== 5'd0 || ifc.wdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_port: wea=%b w1=%0d wdata=%h expected 0/0/0", ifc.wea, ifc.w1, ifc.wdata);
        end
        checks++;
        if (ifc.pending !== 32'd0 || ifc.err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: pending=%h err=%b expected 0/0", ifc.pending, ifc.err);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (ifc.b_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_release: got %b expected 0", ifc.b_ready);
        end
        tick();
        checks++;
        if (ifc.b_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_edge: got %b expected 1", ifc.b_ready);
        end
    endtask

    task automatic test_a_write();
        do_reset();
        ifc.a_valid = 1'b1;
        ifc.a_addr  = 5'd3;
        ifc.a_data  = 32'hDEADBEEF;
        tick();
        idle_inputs();
        checks++;
        if (ifc.wea !== 1'b1 || ifc.w1 !== 5'd3 || ifc.wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL a_write: wea=%b w1=%0d wdata=%h expected 1/3/deadbeef", ifc.wea, ifc.w1, ifc.wdata);
        end
        tick();
        checks++;
        if (ifc.wea !== 1'b0 || ifc.w1 !== 5'd3 || ifc.wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL a_idle_hold: wea=%b w1=%0d wdata=%h expected 0/3/deadbeef", ifc.wea, ifc.w1, ifc.wdata);
        end
    endtask

    task automatic test_b_path();
        do_reset();
        ifc.iss_valid = 1'b1;
        ifc.iss_addr  = 5'd7;
        tick();
        idle_inputs();
        ifc.rs_addr = 5'd7;
        #1;
        checks++;
        if (ifc.hazard !== 1'b1 || ifc.pending[7] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hazard_rs: hazard=%b pend7=%b expected 1/1", ifc.hazard, ifc.pending[7]);
        end
        ifc.rs_addr = 5'd0;
        ifc.rt_addr = 5'd7;
        #1;
        checks++;
        if (ifc.hazard !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hazard_rt: got %b expected 1", ifc.hazard);
        end
        ifc.b_valid = 1'b1;
        ifc.b_addr  = 5'd7;
        ifc.b_data  = 32'h1234;
        tick();
        ifc.b_valid = 1'b0;
`ifndef WB_BYPASS_EN
        checks++;
        if (ifc.wea !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b_min_latency: wea got %b expected 0", ifc.wea);
        end
        tick();
`endif
        checks++;
        if (ifc.wea !== 1'b1 || ifc.w1 !== 5'd7 || ifc.wdata !== 32'h1234) begin
            errors++;
            $display("[TB] FAIL b_write: wea=%b w1=%0d wdata=%h expected 1/7/1234", ifc.wea, ifc.w1, ifc.wdata);
        end
        tick();
        checks++;
        if (ifc.wea !== 1'b0 || ifc.pending[7] !== 1'b0 || ifc.hazard !== 1'b0 || ifc.err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b_commit: wea=%b pend7=%b hazard=%b err=%b expected 0/0/0/0",
                     ifc.wea, ifc.pending[7], ifc.hazard, ifc.err);
        end
    endtask

    task automatic test_priority();
        logic exp_ready;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            ifc.iss_valid = 1'b1;
            ifc.iss_addr  = 5'(10 + k);
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 6; c++) begin
            ifc.a_valid = 1'b1;
            ifc.a_addr  = 5'(c + 1);
            ifc.a_data  = 32'hA000 + 32'(c);
            ifc.b_valid = 1'b1;
            ifc.b_addr  = 5'(10 + ((c < 4) ? c : 4));
            ifc.b_data  = 32'h100 + 32'((c < 4) ? c : 4);
            exp_ready   = (c < 4);
            #1;
            checks++;
            if (ifc.b_ready !== exp_ready) begin
                errors++;
                $display("[TB] FAIL prio_ready[%0d]: got %b expected %b", c, ifc.b_ready, exp_ready);
            end
            tick();
            checks++;
            if (ifc.wea !== 1'b1 || ifc.w1 !== 5'(c + 1) || ifc.wdata !== 32'hA000 + 32'(c)) begin
                errors++;
                $display("[TB] FAIL prio_a[%0d]: wea=%b w1=%0d wdata=%h expected 1/%0d/%h",
                         c, ifc.wea, ifc.w1, ifc.wdata, c + 1, 32'hA000 + 32'(c));
            end
        end
        ifc.a_valid = 1'b0;
        ifc.a_addr  = '0;
        for (int j = 0; j < 5; j++) begin
            ifc.b_valid = (j < 2);
            exp_ready   = (j != 0);
            #1;
            checks++;
            if (ifc.b_ready !== exp_ready) begin
                errors++;
                $display("[TB] FAIL drain_ready[%0d]: got %b expected %b", j, ifc.b_ready, exp_ready);
            end
            tick();
            checks++;
            if (ifc.wea !== 1'b1 || ifc.w1 !== 5'(10 + j) || ifc.wdata !== 32'h100 + 32'(j)) begin
                errors++;
                $display("[TB] FAIL drain_order[%0d]: wea=%b w1=%0d wdata=%h expected 1/%0d/%h",
                         j, ifc.wea, ifc.w1, ifc.wdata, 10 + j, 32'h100 + 32'(j));
            end
        end
        idle_inputs();
        tick();
        checks++;
        if (ifc.wea !== 1'b0 || ifc.pending !== 32'd0 || ifc.err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_end: wea=%b pending=%h err=%b expected 0/0/0", ifc.wea, ifc.pending, ifc.err);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        ifc.iss_valid = 1'b1;
        ifc.iss_addr  = 5'd9;
        tick();
        idle_inputs();
        ifc.b_valid = 1'b1;
        ifc.b_addr  = 5'd9;
        ifc.b_data  = 32'h99;
        tick();
        ifc.b_valid = 1'b0;
`ifndef WB_BYPASS_EN
        tick();
`endif
        checks++;
        if (ifc.wea !== 1'b1 || ifc.w1 !== 5'd9) begin
            errors++;
            $display("[TB] FAIL same_commit: wea=%b w1=%0d expected 1/9", ifc.wea, ifc.w1);
        end
        ifc.iss_valid = 1'b1;
        ifc.iss_addr  = 5'd9;
        tick();
        idle_inputs();
        ifc.rs_addr = 5'd9;
        #1;
        checks++;
        if (ifc.pending[9] !== 1'b1 || ifc.hazard !== 1'b1) begin
            errors++;
            $display("[TB] FAIL set_wins: pend9=%b hazard=%b expected 1/1", ifc.pending[9], ifc.hazard);
        end
        checks++;
        if (ifc.err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reissue_err: got %b expected 1", ifc.err);
        end
    endtask

    task automatic test_r0_and_err();
        do_reset();
        ifc.a_valid = 1'b1;
        ifc.a_addr  = 5'd0;
        ifc.a_data  = 32'h5555;
        ifc.b_valid = 1'b1;
        ifc.b_addr  = 5'd0;
        ifc.b_data  = 32'h6666;
        #1;
        checks++;
        if (ifc.b_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL r0_ready: got %b expected 1", ifc.b_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (ifc.wea !== 1'b0) begin
            errors++;
            $display("[TB] FAIL r0_no_write: wea got %b expected 0", ifc.wea);
        end
        tick();
        checks++;
        if (ifc.wea !== 1'b0 || ifc.err !== 1'b0 || ifc.pending !== 32'd0) begin
            errors++;
            $display("[TB] FAIL r0_no_entry: wea=%b err=%b pending=%h expected 0/0/0", ifc.wea, ifc.err, ifc.pending);
        end
        ifc.iss_valid = 1'b1;
        ifc.iss_addr  = 5'd5;
        tick();
        idle_inputs();
        ifc.a_valid = 1'b1;
        ifc.a_addr  = 5'd5;
        ifc.a_data  = 32'h77;
        tick();
        idle_inputs();
        checks++;
        if (ifc.err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL waw_err: got %b expected 1", ifc.err);
        end
        tick();
        tick();
        checks++;
        if (ifc.err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_sticky: got %b expected 1", ifc.err);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            ifc.iss_valid = 1'b1;
            ifc.iss_addr  = 5'(20 + k);
            tick();
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            ifc.a_valid = 1'b1;
            ifc.a_addr  = 5'd1;
            ifc.b_valid = 1'b1;
            ifc.b_addr  = 5'(20 + k);
            ifc.b_data  = 32'h200 + 32'(k);
            tick();
        end
        idle_inputs();
        ifc.iss_valid = 1'b1;
        ifc.iss_addr  = 5'd20;
        tick();
        idle_inputs();
        checks++;
        if (ifc.wea !== 1'b1 || ifc.w1 !== 5'd20 || ifc.err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset: wea=%b w1=%0d err=%b expected 1/20/1", ifc.wea, ifc.w1, ifc.err);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (ifc.wea !== 1'b0 || ifc.pending !== 32'd0 || ifc.err !== 1'b0 || ifc.b_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: wea=%b pending=%h err=%b ready=%b expected 0/0/0/0",
                     ifc.wea, ifc.pending, ifc.err, ifc.b_ready);
        end
        tick();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (ifc.wea !== 1'b0) begin
                errors++;
                $display("[TB] FAIL post_reset_write[%0d]: wea got %b expected 0", k, ifc.wea);
            end
        end
        checks++;
        if (ifc.b_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_ready: got %b expected 1", ifc.b_ready);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_a_write();
        test_b_path();
        test_priority();
        test_same_cycle();
        test_r0_and_err();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
